mem_org_mode_master: RTL



---
 rtl/mem_org_mode_master_pkg.sv | 18 +
 rtl/mem_org_mode_master_stall_timer.sv | 28 ++
 rtl/mem_org_mode_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_org_mode_master_pkg.sv
// Shared types and constants for the memory-organization mode register initiator.
package mem_org_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RLAT,
    ST_FINISH
  } state_e;

  localparam logic [1:0] STATUS_OK       = 2'd0;
  localparam logic [1:0] STATUS_MISMATCH = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;

  localparam int unsigned CONDUIT_WIDTH_DEF = 2;

endpackage

// File: rtl/mem_org_mode_master_stall_timer.sv
// Saturating waitrequest stall counter shared by the write and read command phases.
module mem_org_stall_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Flags the stalled cycle whose increment brings the count to the limit.
  assign expired_o = inc_i && (cnt_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/mem_org_mode_master.sv
// Avalon-MM initiator: writes a requested mode to the mode register, optionally
// reads it back and compares, then pulses done with a status code.
module mem_org_mode_master
  import mem_org_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CONDUIT_WIDTH  = CONDUIT_WIDTH_DEF,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CONDUIT_WIDTH-1:0] req_mode,
  input  logic                     req_verify,
  output logic                     master_write,
  output logic                     master_read,
  output logic [WIDTH-1:0]         master_writedata,
  input  logic [WIDTH-1:0]         master_readdata,
  input  logic                     master_waitrequest,
  output logic                     done,
  output logic [1:0]               status,
  output logic [CONDUIT_WIDTH-1:0] current_mode,
  output logic                     busy
);

  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  state_e                   state_q, state_d;
  logic [CONDUIT_WIDTH-1:0] mode_q, mode_d;
  logic                     verify_q, verify_d;
  logic [WIDTH-1:0]         wdata_q, wdata_d;
  logic [1:0]               status_q, status_d;
  logic [CONDUIT_WIDTH-1:0] cur_mode_q, cur_mode_d;
  logic [LAT_W-1:0]         lat_q, lat_d;

  logic tmr_clr, tmr_inc, tmr_expired;
  logic unused_rdata;

  mem_org_stall_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      verify_q   <= 1'b0;
      wdata_q    <= '0;
      status_q   <= STATUS_OK;
      cur_mode_q <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      verify_q   <= verify_d;
      wdata_q    <= wdata_d;
      status_q   <= status_d;
      cur_mode_q <= cur_mode_d;
      lat_q      <= lat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    verify_d     = verify_q;
    wdata_d      = wdata_q;
    status_d     = status_q;
    cur_mode_d   = cur_mode_q;
    lat_d        = lat_q;
    master_write = 1'b0;
    master_read  = 1'b0;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (req_valid) begin
          mode_d   = req_mode;
          verify_d = req_verify;
          wdata_d  = WIDTH'(req_mode);
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        master_write = 1'b1;
        if (!master_waitrequest) begin
          tmr_clr    = 1'b1;
          cur_mode_d = mode_q;
          if (verify_q) begin
            state_d = ST_READ;
          end else begin
            status_d = STATUS_OK;
            state_d  = ST_FINISH;
          end
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            status_d = STATUS_TIMEOUT;
            state_d  = ST_FINISH;
          end
        end
      end

      ST_READ: begin
        master_read = 1'b1;
        if (!master_waitrequest) begin
          tmr_clr = 1'b1;
          lat_d   = LAT_W'(READ_LATENCY);
          state_d = ST_RLAT;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            status_d = STATUS_TIMEOUT;
            state_d  = ST_FINISH;
          end
        end
      end

      // lat_q counts down so the final RLAT cycle is READ_LATENCY after acceptance.
      ST_RLAT: begin
        if (lat_q == LAT_W'(1)) begin
          status_d = (master_readdata[CONDUIT_WIDTH-1:0] == mode_q) ? STATUS_OK
                                                                     : STATUS_MISMATCH;
          state_d  = ST_FINISH;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign busy             = ~req_ready;
  assign done             = (state_q == ST_FINISH);
  assign status           = status_q;
  assign current_mode     = cur_mode_q;
  assign master_writedata = wdata_q;
  assign unused_rdata     = ^master_readdata;

endmodule
